uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the UART RX path. Synchronises the serial line,
//  detects and validates the start bit, and times mid-bit sampling. Issues
//  one shift strobe plus sampled bit per data bit to the RX shift register.
//  Flags frame completion or a framing error at the stop bit. One frame is
//  1 start bit, DATA_BITS data bits (LSB first), 1 stop bit; no parity.
// PARAMETERS
//  CLKS_PER_BIT  16  CLK cycles per serial bit; must be >= 4; HALF = CLKS_PER_BIT/2 (floor)
//  DATA_BITS     8   data bits per frame; must equal the shift register SIZE
// PORTS
//  CLK        in   1   system clock, all logic on rising edge
//  RST        in   1   asynchronous, active-high reset
//  EN         in   1   receiver enable; low = hold in IDLE, abort any frame
//  RX         in   1   raw serial line, idle high, asynchronous to CLK
//  SHIFT_EN   out  1   one-cycle strobe: shift register captures SHIFT_DATA
//  SHIFT_DATA out  1   sampled data bit, valid while SHIFT_EN=1
//  RX_DONE    out  1   one-cycle pulse: frame complete, stop bit = 1
//  FRAME_ERR  out  1   one-cycle pulse: stop bit sampled 0
//  BUSY       out  1   1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; counters 0; 2-FF synchroniser preset to 1 (no false start);
//    SHIFT_EN, SHIFT_DATA, RX_DONE, FRAME_ERR, BUSY all 0. Reset is honoured mid-frame.
//  - rx_s = RX after 2 sync FFs. bit_cnt width $clog2(CLKS_PER_BIT); idx width $clog2(DATA_BITS+1).
//  - All outputs registered. Strobes high exactly one cycle.
//  - States: IDLE, START, DATA, STOP, WAIT_IDLE.
//  - IDLE: if EN && rx_s==0 at edge t0 -> START, bit_cnt=0.
//  - START: at edge t0+HALF check rx_s: 0 -> DATA, bit_cnt=0, idx=0.
//    1 -> glitch; go IDLE with no output.
//  - DATA: bit k (k=0..DATA_BITS-1) is sampled at edge t0+HALF+(k+1)*CLKS_PER_BIT.
//    At that edge SHIFT_EN<=1 and SHIFT_DATA<=rx_s; idx++.
//    After bit DATA_BITS-1 -> STOP.
//  - STOP: stop bit is sampled at edge t0+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
//    rx_s==1 -> RX_DONE<=1, IDLE. rx_s==0 -> FRAME_ERR<=1, WAIT_IDLE.
//  - WAIT_IDLE: stays until rx_s==1 (break/stuck-low never re-triggers start), then IDLE.
//  - RX_DONE never coincides with SHIFT_EN; RX_DONE and FRAME_ERR are mutually exclusive.
//  - After RX_DONE the shift register holds data bit 0 in its MSB; the consumer bit-reverses.
//    Shift register contents are not cleared on FRAME_ERR or abort.
//  - EN low at any edge: next state IDLE, counters cleared, no strobes/pulses that cycle.
//  - Back-to-back frames: a start edge seen in IDLE on the cycle right after STOP is accepted.
// TESTING
//  1. CLKS_PER_BIT=16: frame 0xA5 -> 8 SHIFT_EN pulses, SHIFT_DATA 1,0,1,0,0,1,0,1,
//     16 cycles apart, first at t0+24; then RX_DONE once at t0+152; BUSY low after.
//  2. 4-cycle low glitch on RX while idle -> START rejects, no SHIFT_EN, back in IDLE, BUSY 1 for ~9 cycles.
//  3. Frame 0x3C with stop bit driven 0 -> 8 shifts, FRAME_ERR at stop sample, no RX_DONE;
//     hold RX low 100 cycles -> stays WAIT_IDLE; RX high -> IDLE.
//  4. RST pulsed during data bit 4 -> all outputs 0 immediately, IDLE;
//     next full frame 0x81 received correctly.
//  5. EN dropped mid-frame -> IDLE next edge, no further strobes; EN low with RX toggling -> BUSY stays 0.
//  6. Two back-to-back frames 0x00, 0xFF (no idle gap) -> 16 shifts, two RX_DONE pulses 160 cycles apart.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises RX, validates the start bit and
// issues one mid-bit shift strobe per data bit, then checks the stop bit.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic RX,
    output logic SHIFT_EN,
    output logic SHIFT_DATA,
    output logic RX_DONE,
    output logic FRAME_ERR,
    output logic BUSY
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sync1_q, sync2_q;
    logic          shift_en_q, shift_en_d;
    logic          shift_data_q, shift_data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic          rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        shift_en_d   = 1'b0;
        shift_data_d = 1'b0;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                idx_d     = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (bit_cnt_q == HALF_LAST) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d    = '0;
                    shift_en_d   = 1'b1;
                    shift_data_d = rx_s;
                    idx_d        = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (rx_s) begin
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                // a stuck-low line must return high before a new start counts
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!EN) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            idx_d        = '0;
            shift_en_d   = 1'b0;
            shift_data_d = 1'b0;
            rx_done_d    = 1'b0;
            frame_err_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            shift_en_q   <= 1'b0;
            shift_data_q <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            sync1_q      <= RX;
            sync2_q      <= sync1_q;
            shift_en_q   <= shift_en_d;
            shift_data_q <= shift_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign SHIFT_EN   = shift_en_q;
    assign SHIFT_DATA = shift_data_q;
    assign RX_DONE    = rx_done_q;
    assign FRAME_ERR  = frame_err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames, glitch, framing error,
// mid-frame reset, enable drop and back-to-back frames.
module tb_uart_rx_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic EN;
    logic RX;
    logic SHIFT_EN;
    logic SHIFT_DATA;
    logic RX_DONE;
    logic FRAME_ERR;
    logic BUSY;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_busy = 0;
    int n_ovl  = 0;
    int t1;
    int t2;

    logic bits_q[$];
    int   shift_cyc_q[$];
    int   done_cyc_q[$];
    int   ferr_cyc_q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .RX        (RX),
        .SHIFT_EN  (SHIFT_EN),
        .SHIFT_DATA(SHIFT_DATA),
        .RX_DONE   (RX_DONE),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (SHIFT_EN) begin
            bits_q.push_back(SHIFT_DATA);
            shift_cyc_q.push_back(cyc);
        end
        if (RX_DONE) done_cyc_q.push_back(cyc);
        if (FRAME_ERR) ferr_cyc_q.push_back(cyc);
        if (BUSY) n_busy++;
        if ((RX_DONE && SHIFT_EN) || (RX_DONE && FRAME_ERR)) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clr();
        bits_q.delete();
        shift_cyc_q.delete();
        done_cyc_q.delete();
        ferr_cyc_q.delete();
        n_busy = 0;
    endtask

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            if (base + i < bits_q.size()) b[i] = bits_q[base + i];
            else b[i] = 1'bx;
        return b;
    endfunction

    function automatic int first_or(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    // Caller is at negedge+1; the start bit is driven immediately.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              output int t_start);
        t_start = cyc;
        RX = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(16);
        end
        RX = stop_bit;
        tick(16);
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b1;
        RX  = 1'b1;
        tick(3);
        chk("reset_outputs",
            {27'd0, SHIFT_EN, SHIFT_DATA, RX_DONE, FRAME_ERR, BUSY}, 32'd0);
        RST = 1'b0;
        tick(5);

        // 1: single good frame 0xA5
        clr();
        send_frame(8'hA5, 1'b1, t1);
        tick(20);
        chk("t1_shift_count", bits_q.size(), 8);
        chk("t1_data", get_byte(0), 8'hA5);
        chk("t1_first_shift_cyc", first_or(shift_cyc_q, 0), t1 + 27);
        chk("t1_last_shift_cyc", first_or(shift_cyc_q, 7), t1 + 27 + 112);
        chk("t1_done_count", done_cyc_q.size(), 1);
        chk("t1_done_cyc", first_or(done_cyc_q, 0), t1 + 155);
        chk("t1_ferr_count", ferr_cyc_q.size(), 0);
        chk("t1_busy_after", BUSY, 1'b0);

        // 2: 4-cycle glitch rejected by the start check
        clr();
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(20);
        chk("t2_shift_count", bits_q.size(), 0);
        chk("t2_busy_cycles", n_busy, 8);
        chk("t2_busy_after", BUSY, 1'b0);
        chk("t2_pulses", done_cyc_q.size() + ferr_cyc_q.size(), 0);

        // 3: framing error, then stuck-low line
        clr();
        send_frame(8'h3C, 1'b0, t1);
        tick(100);
        chk("t3_shift_count", bits_q.size(), 8);
        chk("t3_data", get_byte(0), 8'h3C);
        chk("t3_ferr_count", ferr_cyc_q.size(), 1);
        chk("t3_ferr_cyc", first_or(ferr_cyc_q, 0), t1 + 155);
        chk("t3_done_count", done_cyc_q.size(), 0);
        chk("t3_busy_wait_idle", BUSY, 1'b1);
        RX = 1'b1;
        tick(5);
        chk("t3_busy_released", BUSY, 1'b0);
        chk("t3_no_restart", bits_q.size(), 8);

        // 4: reset during data bit 4, then a clean 0x81 frame
        clr();
        RX = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            RX = i[0];
            tick(16);
        end
        RX = 1'b1;
        tick(8);
        chk("t4_shifts_before_rst", bits_q.size(), 4);
        chk("t4_busy_before_rst", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("t4_outputs_in_rst",
            {27'd0, SHIFT_EN, SHIFT_DATA, RX_DONE, FRAME_ERR, BUSY}, 32'd0);
        tick(2);
        RST = 1'b0;
        tick(5);
        clr();
        send_frame(8'h81, 1'b1, t1);
        tick(20);
        chk("t4_shift_count", bits_q.size(), 8);
        chk("t4_data", get_byte(0), 8'h81);
        chk("t4_done_cyc", first_or(done_cyc_q, 0), t1 + 155);

        // 5: enable dropped mid-frame, then line toggling while disabled
        clr();
        RX = 1'b0;
        tick(16);
        RX = 1'b1;
        tick(16);
        RX = 1'b0;
        tick(16);
        RX = 1'b1;
        tick(8);
        EN = 1'b0;
        tick(1);
        chk("t5_busy_after_en_drop", BUSY, 1'b0);
        chk("t5_shifts_before_drop", bits_q.size(), 2);
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            RX = ~RX;
            tick(3);
        end
        RX = 1'b1;
        tick(4);
        chk("t5_busy_while_disabled", n_busy, 0);
        chk("t5_no_more_shifts", bits_q.size(), 2);
        chk("t5_no_pulses", done_cyc_q.size() + ferr_cyc_q.size(), 0);
        EN = 1'b1;
        tick(5);

        // 6: back-to-back frames with no idle gap
        clr();
        send_frame(8'h00, 1'b1, t1);
        send_frame(8'hFF, 1'b1, t2);
        tick(20);
        chk("t6_shift_count", bits_q.size(), 16);
        chk("t6_data0", get_byte(0), 8'h00);
        chk("t6_data1", get_byte(8), 8'hFF);
        chk("t6_done_count", done_cyc_q.size(), 2);
        chk("t6_done0_cyc", first_or(done_cyc_q, 0), t1 + 155);
        chk("t6_done_spacing",
            first_or(done_cyc_q, 1) - first_or(done_cyc_q, 0), 160);
        chk("t6_busy_after", BUSY, 1'b0);

        chk("no_overlap_pulses", n_ovl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
